reg_ex_mem_hs: RTL and testbench

Parametrised EX/MEM pipeline register for the RISC-V core; successor to the fixed-width free-running stage register. Adds a valid/ready handshake on both sides, an optional one-entry skid buffer for a fully registered upstream ready, synchronous flush (bubble injection) and a saturating stall counter. It sits between the EX stage (ALU, forwarding muxes) and the MEM stage (data memory, load/store unit).

---
 rtl/reg_ex_mem_hs_pkg.sv | 25 ++
 rtl/reg_ex_mem_hs_pipe_skid_slot.sv | 38 +++
 rtl/reg_ex_mem_hs.sv | 153 +++++++++++++++
 tb/tb_reg_ex_mem_hs.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_ex_mem_hs_pkg.sv
// ---------------------------------------------------------------------------
// reg_ex_mem_hs_pkg
// Shared definitions for the EX/MEM stage register of the RISC-V core.
//   CORE_XLEN        : datapath width (ALU result, store data)
//   CORE_REG_AW      : register-index width (rd, rs2)
//   ex_mem_payload_t : everything EX hands to MEM, packed so that a pipeline
//                      slot (main or skid) is a single register.
// ---------------------------------------------------------------------------
package reg_ex_mem_hs_pkg;

    localparam int CORE_XLEN   = 32;
    localparam int CORE_REG_AW = 5;

    typedef struct packed {
        logic [CORE_XLEN-1:0]   regs_data2;
        logic [CORE_XLEN-1:0]   alu_o;
        logic [CORE_REG_AW-1:0] rd;
        logic [CORE_REG_AW-1:0] rs2;
        logic                   mem_read;
        logic                   mem2reg;
        logic                   mem_write;
        logic                   regs_write;
    } ex_mem_payload_t;

endpackage

// File: rtl/reg_ex_mem_hs_pipe_skid_slot.sv
// ---------------------------------------------------------------------------
// pipe_skid_slot
// One pipeline slot: a valid bit plus a payload register.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset (valid and payload cleared)
//   load  : capture d and mark the slot valid
//   clear : mark the slot invalid; wins over load, and then d is not captured
//   d     : incoming payload
//   valid : slot holds a live entry
//   q     : stored payload (holds its value when not loaded)
// ---------------------------------------------------------------------------
module pipe_skid_slot
    import reg_ex_mem_hs_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  ex_mem_payload_t d,
    output logic            valid,
    output ex_mem_payload_t q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            if (clear) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
                q     <= d;
            end
        end
    end

endmodule

// File: rtl/reg_ex_mem_hs.sv
// ---------------------------------------------------------------------------
// reg_ex_mem_hs
// EX/MEM pipeline register with valid/ready handshake on both sides, optional
// one-entry skid buffer, synchronous flush and a saturating stall counter.
//
// Parameters:
//   XLEN, REG_AW : payload widths (must match the package payload layout)
//   SKID_EN      : 1 = main + skid slot, ex_ready is a register output
//                  0 = main slot only, ex_ready = ~me_valid | me_ready
//   STALL_CNT_W  : width of stall_cnt
//
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   flush                     : drop every held and incoming entry this cycle
//   ex_valid / ex_ready       : upstream handshake
//   ex_regs_data2, ex_alu_o   : store data, ALU result / address
//   ex_rd, ex_rs2             : destination and rs2 register indices
//   ex_mem_read, ex_mem2reg,
//   ex_mem_write, ex_regs_write : control bits
//   me_valid / me_ready       : downstream handshake
//   me_*                      : registered payload; control bits gated by me_valid
//   stall_cnt                 : cycles with me_valid & ~me_ready, saturating
//
// Handshake: a side transfers on a rising edge where its valid and ready are
// both high. valid never depends on ready of the same side; once valid is
// raised by this block its payload stays stable until the transfer (or flush).
// ---------------------------------------------------------------------------
module reg_ex_mem_hs
    import reg_ex_mem_hs_pkg::*;
#(
    parameter int XLEN        = CORE_XLEN,
    parameter int REG_AW      = CORE_REG_AW,
    parameter int SKID_EN     = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [XLEN-1:0]        ex_regs_data2,
    input  logic [XLEN-1:0]        ex_alu_o,
    input  logic [REG_AW-1:0]      ex_rd,
    input  logic [REG_AW-1:0]      ex_rs2,
    input  logic                   ex_mem_read,
    input  logic                   ex_mem2reg,
    input  logic                   ex_mem_write,
    input  logic                   ex_regs_write,
    output logic                   me_valid,
    input  logic                   me_ready,
    output logic [XLEN-1:0]        me_regs_data2,
    output logic [XLEN-1:0]        me_alu_o,
    output logic [REG_AW-1:0]      me_rd,
    output logic [REG_AW-1:0]      me_rs2,
    output logic                   me_mem_read,
    output logic                   me_mem2reg,
    output logic                   me_mem_write,
    output logic                   me_regs_write,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    ex_mem_payload_t in_pl;
    ex_mem_payload_t main_d;
    ex_mem_payload_t main_q;
    ex_mem_payload_t skid_q;
    logic            main_valid;
    logic            skid_valid;
    logic            in_fire;
    logic            out_fire;
    logic            main_free;
    logic            main_load;
    logic            main_clear;

    always_comb begin
        in_pl            = '0;
        in_pl.regs_data2 = ex_regs_data2;
        in_pl.alu_o      = ex_alu_o;
        in_pl.rd         = ex_rd;
        in_pl.rs2        = ex_rs2;
        in_pl.mem_read   = ex_mem_read;
        in_pl.mem2reg    = ex_mem2reg;
        in_pl.mem_write  = ex_mem_write;
        in_pl.regs_write = ex_regs_write;
    end

    assign in_fire  = ex_valid & ex_ready;
    assign out_fire = main_valid & me_ready;

    // Main can take a new entry when it is empty or its entry leaves now.
    // The skid entry is older than anything upstream, so it goes first.
    assign main_free  = ~main_valid | out_fire;
    assign main_load  = main_free & (skid_valid | in_fire);
    assign main_d     = skid_valid ? skid_q : in_pl;
    assign main_clear = flush | (out_fire & ~main_load);

    pipe_skid_slot u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            logic skid_load;
            logic skid_clear;

            // ex_ready is ~skid_valid, so an accepted input always finds the
            // skid empty; it parks there only when main cannot take it.
            assign skid_load  = in_fire & ~main_free;
            assign skid_clear = flush | (skid_valid & main_free);
            assign ex_ready   = ~skid_valid;

            pipe_skid_slot u_skid (
                .clk   (clk),
                .rst   (rst),
                .load  (skid_load),
                .clear (skid_clear),
                .d     (in_pl),
                .valid (skid_valid),
                .q     (skid_q)
            );
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_q     = '0;
            assign ex_ready   = ~main_valid | me_ready;
        end
    endgenerate

    assign me_valid      = main_valid;
    assign me_regs_data2 = main_q.regs_data2;
    assign me_alu_o      = main_q.alu_o;
    assign me_rd         = main_q.rd;
    assign me_rs2        = main_q.rs2;
    // A bubble must never write memory or the register file.
    assign me_mem_read   = main_q.mem_read   & main_valid;
    assign me_mem2reg    = main_q.mem2reg    & main_valid;
    assign me_mem_write  = main_q.mem_write  & main_valid;
    assign me_regs_write = main_q.regs_write & main_valid;

    // Counts backpressure cycles; survives flush, only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !me_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_reg_ex_mem_hs.sv
// ---------------------------------------------------------------------------
// tb_reg_ex_mem_hs
// Two instances share one stimulus stream: dut1 (SKID_EN=1, STALL_CNT_W=4)
// and dut0 (SKID_EN=0, STALL_CNT_W=16). A queue model of each (capacity 2
// resp. 1) is checked every cycle, plus directed literal expectations.
// ---------------------------------------------------------------------------
module tb_reg_ex_mem_hs;
    import reg_ex_mem_hs_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared inputs ----------------
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_regs_data2 = '0;
    logic [31:0] ex_alu_o = '0;
    logic [4:0]  ex_rd = '0;
    logic [4:0]  ex_rs2 = '0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem2reg = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic        ex_regs_write = 1'b0;
    logic        me_ready = 1'b0;

    // ---------------- outputs ----------------
    logic        ex_ready_1, me_valid_1, me_mem_read_1, me_mem2reg_1, me_mem_write_1, me_regs_write_1;
    logic [31:0] me_regs_data2_1, me_alu_o_1;
    logic [4:0]  me_rd_1, me_rs2_1;
    logic [3:0]  stall_cnt_1;
    logic        ex_ready_0, me_valid_0, me_mem_read_0, me_mem2reg_0, me_mem_write_0, me_regs_write_0;
    logic [31:0] me_regs_data2_0, me_alu_o_0;
    logic [4:0]  me_rd_0, me_rs2_0;
    logic [15:0] stall_cnt_0;

    reg_ex_mem_hs #(.XLEN(32), .REG_AW(5), .SKID_EN(1), .STALL_CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready_1),
        .ex_regs_data2(ex_regs_data2), .ex_alu_o(ex_alu_o), .ex_rd(ex_rd), .ex_rs2(ex_rs2),
        .ex_mem_read(ex_mem_read), .ex_mem2reg(ex_mem2reg),
        .ex_mem_write(ex_mem_write), .ex_regs_write(ex_regs_write),
        .me_valid(me_valid_1), .me_ready(me_ready),
        .me_regs_data2(me_regs_data2_1), .me_alu_o(me_alu_o_1), .me_rd(me_rd_1), .me_rs2(me_rs2_1),
        .me_mem_read(me_mem_read_1), .me_mem2reg(me_mem2reg_1),
        .me_mem_write(me_mem_write_1), .me_regs_write(me_regs_write_1),
        .stall_cnt(stall_cnt_1)
    );

    reg_ex_mem_hs #(.XLEN(32), .REG_AW(5), .SKID_EN(0), .STALL_CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready_0),
        .ex_regs_data2(ex_regs_data2), .ex_alu_o(ex_alu_o), .ex_rd(ex_rd), .ex_rs2(ex_rs2),
        .ex_mem_read(ex_mem_read), .ex_mem2reg(ex_mem2reg),
        .ex_mem_write(ex_mem_write), .ex_regs_write(ex_regs_write),
        .me_valid(me_valid_0), .me_ready(me_ready),
        .me_regs_data2(me_regs_data2_0), .me_alu_o(me_alu_o_0), .me_rd(me_rd_0), .me_rs2(me_rs2_0),
        .me_mem_read(me_mem_read_0), .me_mem2reg(me_mem2reg_0),
        .me_mem_write(me_mem_write_0), .me_regs_write(me_regs_write_0),
        .stall_cnt(stall_cnt_0)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each stage is a FIFO of capacity 2 (skid) or 1 (no skid); head = output.
    ex_mem_payload_t q1[$];
    ex_mem_payload_t q0[$];
    int unsigned     cnt1 = 0;
    int unsigned     cnt0 = 0;

    function automatic ex_mem_payload_t cur_in();
        ex_mem_payload_t p;
        p.regs_data2 = ex_regs_data2;
        p.alu_o      = ex_alu_o;
        p.rd         = ex_rd;
        p.rs2        = ex_rs2;
        p.mem_read   = ex_mem_read;
        p.mem2reg    = ex_mem2reg;
        p.mem_write  = ex_mem_write;
        p.regs_write = ex_regs_write;
        return p;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q1.delete();
            q0.delete();
            cnt1 = 0;
            cnt0 = 0;
        end else begin
            ex_mem_payload_t p;
            bit acc1, acc0, pop1, pop0;
            p    = cur_in();
            acc1 = ex_valid && (q1.size() < 2);
            acc0 = ex_valid && (q0.size() == 0 || me_ready);
            pop1 = (q1.size() > 0) && me_ready;
            pop0 = (q0.size() > 0) && me_ready;
            if (q1.size() > 0 && !me_ready && cnt1 < 15)    cnt1++;
            if (q0.size() > 0 && !me_ready && cnt0 < 65535) cnt0++;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (pop1) void'(q1.pop_front());
                if (pop0) void'(q0.pop_front());
                if (acc1) q1.push_back(p);
                if (acc0) q0.push_back(p);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        ex_mem_payload_t h1, h0;
        bit v1, v0;
        v1 = q1.size() > 0;
        v0 = q0.size() > 0;
        h1 = v1 ? q1[0] : '0;
        h0 = v0 ? q0[0] : '0;
        chk("ex_ready_1", ex_ready_1, q1.size() < 2);
        chk("me_valid_1", me_valid_1, v1);
        chk("mem_read_1", me_mem_read_1, h1.mem_read);
        chk("mem2reg_1", me_mem2reg_1, h1.mem2reg);
        chk("mem_write_1", me_mem_write_1, h1.mem_write);
        chk("regs_write_1", me_regs_write_1, h1.regs_write);
        chk("stall_cnt_1", stall_cnt_1, cnt1);
        if (v1) begin
            chk("alu_o_1", me_alu_o_1, h1.alu_o);
            chk("regs_data2_1", me_regs_data2_1, h1.regs_data2);
            chk("rd_1", me_rd_1, h1.rd);
            chk("rs2_1", me_rs2_1, h1.rs2);
        end
        chk("ex_ready_0", ex_ready_0, (q0.size() == 0) || me_ready);
        chk("me_valid_0", me_valid_0, v0);
        chk("mem_read_0", me_mem_read_0, h0.mem_read);
        chk("mem2reg_0", me_mem2reg_0, h0.mem2reg);
        chk("mem_write_0", me_mem_write_0, h0.mem_write);
        chk("regs_write_0", me_regs_write_0, h0.regs_write);
        chk("stall_cnt_0", stall_cnt_0, cnt0);
        if (v0) begin
            chk("alu_o_0", me_alu_o_0, h0.alu_o);
            chk("regs_data2_0", me_regs_data2_0, h0.regs_data2);
            chk("rd_0", me_rd_0, h0.rd);
            chk("rs2_0", me_rs2_0, h0.rs2);
        end
    end

    // Log of ALU values leaving dut1, sampled at the transfer edge.
    logic [31:0] sink_q[$];
    always @(posedge clk) begin
        if (rst && me_valid_1 && me_ready) sink_q.push_back(me_alu_o_1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                         input logic mr, input logic mw, input logic rw, input logic rdy);
        ex_valid      = v;
        ex_alu_o      = alu;
        ex_regs_data2 = alu ^ 32'hA5A5_0000;
        ex_rd         = rd;
        ex_rs2        = rd + 5'd1;
        ex_mem_read   = mr;
        ex_mem2reg    = mr;
        ex_mem_write  = mw;
        ex_regs_write = rw;
        me_ready      = rdy;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        sink_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] got0, got1, got2;

        // Reset state
        do_reset();
        chk("rst_me_valid", me_valid_1, 1'b0);
        chk("rst_ex_ready", ex_ready_1, 1'b1);
        chk("rst_stall", stall_cnt_1, 4'd0);

        // Single transfer, 1-cycle latency
        drive(1'b1, 32'h0000_1000, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("t1_me_valid", me_valid_1, 1'b1);
        chk("t1_alu", me_alu_o_1, 32'h0000_1000);
        chk("t1_rd", me_rd_1, 5'd5);
        chk("t1_regs_write", me_regs_write_1, 1'b1);
        chk("t1_stall", stall_cnt_1, 4'd0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("t1_drained", me_valid_1, 1'b0);

        // Back-to-back A,B,C with two stall cycles
        do_reset();
        drive(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h22, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bb_skid_full_ready", ex_ready_1, 1'b0);
        drive(1'b1, 32'h33, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("bb_hold_A", me_alu_o_1, 32'h11);
        chk("bb_stall2", stall_cnt_1, 4'd2);
        drive(1'b1, 32'h33, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("bb_main_B", me_alu_o_1, 32'h22);
        tick();
        chk("bb_main_C", me_alu_o_1, 32'h33);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("bb_sink_n", sink_q.size(), 3);
        got0 = (sink_q.size() > 0) ? sink_q[0] : 32'hDEAD;
        got1 = (sink_q.size() > 1) ? sink_q[1] : 32'hDEAD;
        got2 = (sink_q.size() > 2) ? sink_q[2] : 32'hDEAD;
        chk("bb_order_A", got0, 32'h11);
        chk("bb_order_B", got1, 32'h22);
        chk("bb_order_C", got2, 32'h33);
        chk("bb_stall_final", stall_cnt_1, 4'd2);

        // Flush with main=A(mem_write), skid=B, C on the input
        do_reset();
        drive(1'b1, 32'hA0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hB0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'hC0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_me_valid", me_valid_1, 1'b0);
        chk("fl_mem_write", me_mem_write_1, 1'b0);
        chk("fl_stall_kept", stall_cnt_1, 4'd2);
        // Flush while an input is actually accepted
        drive(1'b1, 32'hD0, 5'd10, 1'b0, 1'b1, 1'b1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_in_fire_dropped", me_valid_1, 1'b0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk("fl_sink_empty", sink_q.size(), 0);

        // Bubble gating
        drive(1'b0, 32'h77, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        chk("bub_mem_write", me_mem_write_1, 1'b0);
        chk("bub_regs_write", me_regs_write_1, 1'b0);

        // Saturation of the 4-bit counter
        do_reset();
        drive(1'b1, 32'h55, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) tick();
        chk("sat_stall_15", stall_cnt_1, 4'd15);
        chk("sat_still_valid", me_valid_1, 1'b1);

        // No-skid instance: combinational ready, full throughput, async reset
        do_reset();
        drive(1'b1, 32'h61, 5'd11, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 32'h62, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 chk("ns_ready_r1", ex_ready_0, 1'b1);
        me_ready = 1'b0;
        #1 chk("ns_ready_r0", ex_ready_0, 1'b0);
        me_ready = 1'b1;
        #1 chk("ns_ready_r1b", ex_ready_0, 1'b1);
        tick();
        chk("ns_tput_B", me_alu_o_0, 32'h62);
        drive(1'b1, 32'h63, 5'd13, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("ns_tput_C", me_alu_o_0, 32'h63);
        chk("ns_valid_C", me_valid_0, 1'b1);
        #1 rst = 1'b0;
        #1 chk("ns_async_valid0", me_valid_0, 1'b0);
        chk("ns_async_valid1", me_valid_1, 1'b0);
        chk("ns_async_rw0", me_regs_write_0, 1'b0);
        rst = 1'b1;
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
